// File: rtl/freq_peak_tracker.sv
// Hill-climb frequency tracker: finds the peak ADC magnitude in each window, compares
// consecutive windows and steps freq_code up or down until the peak stops improving.
module freq_peak_tracker #(
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned TWOS_COMP  = 1,
  parameter int unsigned WIN_LEN    = 5000,
  parameter int unsigned SETTLE_CYC = 256,
  parameter int unsigned CONFIRM    = 2,
  parameter int unsigned FREQ_W     = 16,
  parameter int unsigned F_MIN      = 0,
  parameter int unsigned F_MAX      = 65535,
  parameter int unsigned F_INIT     = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic [ADC_W-2:0]  threshold,
  input  logic [FREQ_W-1:0] step,
  output logic [FREQ_W-1:0] freq_code,
  output logic              freq_update,
  output logic              freq_dir,
  output logic              freq_opt,
  output logic [ADC_W-2:0]  peak_out
);

  localparam int unsigned MAG_W  = ADC_W - 1;
  localparam int unsigned FX_W   = FREQ_W + 1;
  localparam int unsigned WCNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned CONF_W = $clog2(CONFIRM + 1);

  localparam logic [WCNT_W-1:0] WIN_LAST    = WCNT_W'(WIN_LEN - 1);
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
  localparam logic [CONF_W-1:0] CONF_LAST   = CONF_W'(CONFIRM);
  localparam logic [FX_W-1:0]   F_MIN_X     = FX_W'(F_MIN);
  localparam logic [FX_W-1:0]   F_MAX_X     = FX_W'(F_MAX);
  localparam logic [FREQ_W-1:0] F_MIN_C     = FREQ_W'(F_MIN);
  localparam logic [FREQ_W-1:0] F_MAX_C     = FREQ_W'(F_MAX);
  localparam logic [FREQ_W-1:0] F_INIT_C    = FREQ_W'(F_INIT);

  typedef enum logic [2:0] {
    S_IDLE, S_MEASURE, S_COMPARE, S_STEP, S_SETTLE, S_LOCKED
  } state_e;

  state_e              state_q;
  logic [FREQ_W-1:0]   freq_code_q;
  logic                freq_update_q;
  logic                freq_dir_q;
  logic                freq_opt_q;
  logic [MAG_W-1:0]    peak_out_q;
  logic [MAG_W-1:0]    new_peak_q;
  logic [MAG_W-1:0]    old_peak_q;
  logic [WCNT_W-1:0]   win_cnt_q;
  logic [SCNT_W-1:0]   settle_cnt_q;
  logic [CONF_W-1:0]   confirm_q;
  logic                first_q;

  logic [MAG_W-1:0]    mag_d;
  logic [MAG_W-1:0]    diff_d;
  logic [CONF_W-1:0]   confirm_d;
  logic [FX_W-1:0]     up_sum_d;
  logic [FX_W-1:0]     dn_sum_d;
  logic [FREQ_W-1:0]   code_d;
  logic                dir_d;

  // Sample magnitude; inverting the low bits of negative codes keeps full scale in range.
  // For offset binary, mid-1-x below the midpoint is exactly the inverted low bits.
  generate
    if (TWOS_COMP != 0) begin : g_tc
      always_comb begin
        mag_d = adc_data[ADC_W-1] ? ~adc_data[ADC_W-2:0] : adc_data[ADC_W-2:0];
      end
    end else begin : g_ob
      always_comb begin
        mag_d = adc_data[ADC_W-1] ? adc_data[ADC_W-2:0] : ~adc_data[ADC_W-2:0];
      end
    end
  endgenerate

  always_comb begin
    diff_d    = (new_peak_q >= old_peak_q) ? (new_peak_q - old_peak_q) : (old_peak_q - new_peak_q);
    confirm_d = confirm_q + CONF_W'(1);
  end

  // Next frequency code with clamping; a clamp turns the climb around.
  always_comb begin
    up_sum_d = {1'b0, freq_code_q} + {1'b0, step};
    dn_sum_d = {1'b0, freq_code_q} - {1'b0, step};
    code_d   = freq_code_q;
    dir_d    = freq_dir_q;
    if (freq_dir_q) begin
      if (up_sum_d > F_MAX_X) begin
        code_d = F_MAX_C;
        dir_d  = 1'b0;
      end else begin
        code_d = up_sum_d[FREQ_W-1:0];
      end
    end else begin
      if (dn_sum_d[FREQ_W] || (dn_sum_d < F_MIN_X)) begin
        code_d = F_MIN_C;
        dir_d  = 1'b1;
      end else begin
        code_d = dn_sum_d[FREQ_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      freq_code_q   <= F_INIT_C;
      freq_update_q <= 1'b0;
      freq_dir_q    <= 1'b1;
      freq_opt_q    <= 1'b0;
      peak_out_q    <= '0;
      new_peak_q    <= '0;
      old_peak_q    <= '0;
      win_cnt_q     <= '0;
      settle_cnt_q  <= '0;
      confirm_q     <= '0;
      first_q       <= 1'b0;
    end else begin
      freq_update_q <= 1'b0;
      if (!enable) begin
        state_q    <= S_IDLE;
        freq_opt_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q     <= S_MEASURE;
            freq_code_q <= F_INIT_C;
            freq_dir_q  <= 1'b1;
            first_q     <= 1'b1;
            confirm_q   <= '0;
            new_peak_q  <= '0;
            win_cnt_q   <= '0;
          end
          S_MEASURE: begin
            if (adc_valid) begin
              if (mag_d > new_peak_q) begin
                new_peak_q <= mag_d;
              end
              if (win_cnt_q == WIN_LAST) begin
                win_cnt_q <= '0;
                state_q   <= S_COMPARE;
              end else begin
                win_cnt_q <= win_cnt_q + WCNT_W'(1);
              end
            end
          end
          S_COMPARE: begin
            peak_out_q <= new_peak_q;
            old_peak_q <= new_peak_q;
            state_q    <= S_STEP;
            if (first_q) begin
              first_q <= 1'b0;
            end else if (diff_d <= threshold) begin
              if (confirm_d == CONF_LAST) begin
                confirm_q  <= '0;
                freq_opt_q <= 1'b1;
                state_q    <= S_LOCKED;
              end else begin
                confirm_q <= confirm_d;
              end
            end else begin
              confirm_q <= '0;
              if (new_peak_q < old_peak_q) begin
                freq_dir_q <= ~freq_dir_q;
              end
            end
          end
          S_STEP: begin
            freq_code_q   <= code_d;
            freq_dir_q    <= dir_d;
            freq_update_q <= (code_d != freq_code_q);
            new_peak_q    <= '0;
            win_cnt_q     <= '0;
            settle_cnt_q  <= '0;
            state_q       <= (SETTLE_CYC == 0) ? S_MEASURE : S_SETTLE;
          end
          S_SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
              state_q <= S_MEASURE;
            end else begin
              settle_cnt_q <= settle_cnt_q + SCNT_W'(1);
            end
          end
          S_LOCKED: begin
            if (restart) begin
              state_q    <= S_MEASURE;
              first_q    <= 1'b1;
              confirm_q  <= '0;
              freq_opt_q <= 1'b0;
              new_peak_q <= '0;
              win_cnt_q  <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign freq_code   = freq_code_q;
  assign freq_update = freq_update_q;
  assign freq_dir    = freq_dir_q;
  assign freq_opt    = freq_opt_q;
  assign peak_out    = peak_out_q;

endmodule

// File: tb/tb_freq_peak_tracker.sv
// Directed bench for freq_peak_tracker: climb, reversal, lock/restart, code bounds,
// magnitude extremes with sample gaps, and asynchronous reset mid-window.
module tb_freq_peak_tracker;

  localparam int unsigned ADC_W  = 12;
  localparam int unsigned FREQ_W = 16;

  logic              clk;
  logic              rst;
  logic              enable_a;
  logic              enable_b;
  logic              restart;
  logic              adc_valid;
  logic [ADC_W-1:0]  adc_data;
  logic [ADC_W-2:0]  threshold;
  logic [FREQ_W-1:0] step;

  logic [FREQ_W-1:0] code_a, code_b;
  logic              upd_a, upd_b;
  logic              dir_a, dir_b;
  logic              opt_a, opt_b;
  logic [ADC_W-2:0]  peak_a, peak_b;

  int n_checks;
  int n_fail;
  int pulses_a;
  int pulses_b;
  int last_a;
  int last_b;

  freq_peak_tracker #(
    .ADC_W(ADC_W), .TWOS_COMP(1), .WIN_LEN(8), .SETTLE_CYC(4), .CONFIRM(2),
    .FREQ_W(FREQ_W), .F_MIN(0), .F_MAX(65535), .F_INIT(32768)
  ) u_dut_a (
    .clk(clk), .rst(rst), .enable(enable_a), .restart(restart),
    .adc_valid(adc_valid), .adc_data(adc_data), .threshold(threshold), .step(step),
    .freq_code(code_a), .freq_update(upd_a), .freq_dir(dir_a), .freq_opt(opt_a),
    .peak_out(peak_a)
  );

  freq_peak_tracker #(
    .ADC_W(ADC_W), .TWOS_COMP(1), .WIN_LEN(8), .SETTLE_CYC(4), .CONFIRM(2),
    .FREQ_W(FREQ_W), .F_MIN(32900), .F_MAX(33000), .F_INIT(32950)
  ) u_dut_b (
    .clk(clk), .rst(rst), .enable(enable_b), .restart(restart),
    .adc_valid(adc_valid), .adc_data(adc_data), .threshold(threshold), .step(step),
    .freq_code(code_b), .freq_update(upd_b), .freq_dir(dir_b), .freq_opt(opt_b),
    .peak_out(peak_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of each update strobe; a stretched pulse shows up as an extra count.
  always @(posedge clk) begin
    if (upd_a === 1'b1) pulses_a <= pulses_a + 1;
    if (upd_b === 1'b1) pulses_b <= pulses_b + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic [ADC_W-1:0] d, input int gap);
    adc_valid = 1'b1;
    adc_data  = d;
    tick(1);
    adc_valid = 1'b0;
    adc_data  = '0;
    if (gap > 0) tick(gap);
  endtask

  // Eight back-to-back samples whose maximum is pk, then enough idle cycles for compare/step/settle.
  task automatic window(input int pk);
    for (int i = 0; i < 8; i++) send((i == 3) ? 12'(pk) : 12'(pk - 10), 0);
    tick(10);
  endtask

  task automatic expect_out(input string tag, input bit sel, input int code, input int dir,
                            input int opt, input int pk, input int pulses);
    int now;
    now = sel ? pulses_b : pulses_a;
    check({tag, " code"},   sel ? 32'(code_b) : 32'(code_a), 32'(code));
    check({tag, " dir"},    sel ? 32'(dir_b)  : 32'(dir_a),  32'(dir));
    check({tag, " opt"},    sel ? 32'(opt_b)  : 32'(opt_a),  32'(opt));
    check({tag, " peak"},   sel ? 32'(peak_b) : 32'(peak_a), 32'(pk));
    check({tag, " pulses"}, 32'(now - (sel ? last_b : last_a)), 32'(pulses));
    if (sel) last_b = now; else last_a = now;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    pulses_a = 0; pulses_b = 0; last_a = 0; last_b = 0;
    rst = 1'b1; enable_a = 1'b0; enable_b = 1'b0; restart = 1'b0;
    adc_valid = 1'b0; adc_data = '0; threshold = 11'd2; step = 16'd100;
    tick(3);
    expect_out("reset_a", 1'b0, 32768, 1, 0, 0, 0);
    check("reset_a upd", 32'(upd_a), 32'd0);
    expect_out("reset_b", 1'b1, 32950, 1, 0, 0, 0);
    rst = 1'b0;
    tick(2);

    // Climb, reversal, confirm clearing, lock
    enable_a = 1'b1;
    tick(1);
    check("enable code", 32'(code_a), 32'd32768);
    window(400); expect_out("w400", 1'b0, 32868, 1, 0, 400, 1);
    window(500); expect_out("w500", 1'b0, 32968, 1, 0, 500, 1);
    window(600); expect_out("w600", 1'b0, 33068, 1, 0, 600, 1);
    window(450); expect_out("w450", 1'b0, 32968, 0, 0, 450, 1);
    window(451); expect_out("w451", 1'b0, 32868, 0, 0, 451, 1);
    window(700); expect_out("w700", 1'b0, 32768, 0, 0, 700, 1);
    window(701); expect_out("w701", 1'b0, 32668, 0, 0, 701, 1);
    window(702); expect_out("w702", 1'b0, 32668, 0, 1, 702, 0);
    window(703); expect_out("locked", 1'b0, 32668, 0, 1, 702, 0);

    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check("restart opt", 32'(opt_a), 32'd0);
    window(100); expect_out("w_restart", 1'b0, 32568, 0, 0, 100, 1);

    enable_a = 1'b0;
    tick(2);
    expect_out("disable", 1'b0, 32568, 0, 0, 100, 0);

    // Bounds on the second instance
    enable_b = 1'b1;
    tick(1);
    window(400); expect_out("b_clamp_hi", 1'b1, 33000, 0, 0, 400, 1);
    window(500); expect_out("b_down",     1'b1, 32900, 0, 0, 500, 1);
    window(600); expect_out("b_clamp_lo", 1'b1, 32900, 1, 0, 600, 0);
    step = 16'd0;
    window(700); expect_out("b_step0",    1'b1, 32900, 1, 0, 700, 0);
    enable_b = 1'b0;
    step = 16'd100;
    tick(2);

    // Magnitude extremes with valid gaps
    enable_a = 1'b1;
    tick(1);
    check("reenable code", 32'(code_a), 32'd32768);
    check("reenable dir",  32'(dir_a),  32'd1);
    for (int i = 0; i < 8; i++) send(12'hFFF, 1);
    tick(10);
    expect_out("mag_fff", 1'b0, 32868, 1, 0, 0, 1);
    send(12'h800, 2);
    for (int i = 0; i < 6; i++) send(12'h001, 2);
    tick(4);
    check("seven_valid peak", 32'(peak_a), 32'd0);
    check("seven_valid code", 32'(code_a), 32'd32868);
    send(12'h001, 0);
    tick(10);
    expect_out("mag_800", 1'b0, 32968, 1, 0, 2047, 1);
    send(12'h7FF, 3);
    for (int i = 0; i < 7; i++) send(12'h010, 3);
    tick(10);
    expect_out("mag_7ff", 1'b0, 33068, 1, 0, 2047, 1);

    // Asynchronous reset mid-window
    for (int i = 0; i < 3; i++) send(12'h100, 0);
    rst = 1'b1;
    #2;
    check("async code", 32'(code_a), 32'd32768);
    check("async opt",  32'(opt_a),  32'd0);
    check("async upd",  32'(upd_a),  32'd0);
    check("async peak", 32'(peak_a), 32'd0);
    enable_a = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    expect_out("after_rst", 1'b0, 32768, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
